// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (loader > data > fetch) for the single CPU memory port.
// Define MEM_ARB_TIMEOUT_EN to abort memory accesses that never complete.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [1:0]    grant_id,
    output logic          timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_LD   = 2'd1;
    localparam logic [1:0] ID_IF   = 2'd2;
    localparam logic [1:0] ID_D    = 2'd3;

    logic [1:0]    state;
    logic [1:0]    grant_q;
    logic [1:0]    mask_id;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          ld_v;
    logic          if_v;
    logic          d_v;
    logic [1:0]    win;
    logic          abort;

    // The requester served last sits out the first IDLE cycle.
    always_comb begin
        ld_v = ld_req && (mask_id != ID_LD);
        d_v  = d_req  && (mask_id != ID_D);
        if_v = if_req && (mask_id != ID_IF);
        win  = ID_NONE;
        priority case (1'b1)
            ld_v:    win = ID_LD;
            d_v:     win = ID_D;
            if_v:    win = ID_IF;
            default: win = ID_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant_q    <= ID_NONE;
            mask_id    <= ID_NONE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    mask_id <= ID_NONE;
                    if (win != ID_NONE) begin
                        state   <= S_ISSUE;
                        grant_q <= win;
                        unique case (win)
                            ID_LD: begin
                                we_q    <= ld_we;
                                addr_q  <= ld_addr;
                                wdata_q <= ld_wdata;
                            end
                            ID_D: begin
                                we_q    <= d_we;
                                addr_q  <= d_addr;
                                wdata_q <= d_wdata;
                            end
                            default: begin
                                we_q    <= 1'b0;
                                addr_q  <= if_addr;
                                wdata_q <= '0;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    if (mem_ack) begin
                        state <= S_RESP;
                        if (grant_q == ID_IF) if_rdata_q <= mem_rdata;
                        if (grant_q == ID_D)  d_rdata_q  <= mem_rdata;
                    end else if (abort) begin
                        state <= S_RESP;
                        if (grant_q == ID_IF) if_rdata_q <= '1;
                        if (grant_q == ID_D)  d_rdata_q  <= '1;
                    end
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    grant_q <= ID_NONE;
                    mask_id <= grant_q;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] tmo_cnt;
    logic          err_q;

    assign abort = (state == S_ISSUE) && !mem_ack && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == S_ISSUE) ? tmo_cnt + CW'(1) : '0;
            if (abort) err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo  = ^TIMEOUT;
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign mem_req   = (state == S_ISSUE);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign ld_ack   = (state == S_RESP) && (grant_q == ID_LD);
    assign if_ack   = (state == S_RESP) && (grant_q == ID_IF);
    assign d_ack    = (state == S_RESP) && (grant_q == ID_D);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign grant_id = grant_q;

endmodule
